cpu_fetch_queue: RTL and testbench

- Prefetching instruction-fetch unit for the next-generation RV32 core.
- Replaces the inline fetch-issue/fetch-read states of the multicycle CPU.
- Runs ahead of decode using the same request/ready bus handshake and buffers fetched words in a parametrised FIFO.
- Decode pops entries and redirects the unit on jumps and branches; stale in-flight data is discarded.

---
 rtl/cpu_fetch_queue.sv | 176 +++++++++++++++++
 tb/tb_cpu_fetch_queue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch_queue.sv
// Prefetching instruction-fetch unit: runs ahead of decode over a request/ready bus and buffers words in a FIFO.
// Optional performance counters are built when CPU_FETCH_PERF_EN is defined.
module cpu_fetch_queue #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEPTH        = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0200
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    output logic                    o_rw,
    output logic                    o_request,
    input  logic                    i_ready,
    output logic [ADDR_WIDTH-1:0]   o_address,
    input  logic [DATA_WIDTH-1:0]   i_data,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_instruction,
    output logic [ADDR_WIDTH-1:0]   o_pc,
    input  logic                    i_accept,
    input  logic                    i_jump,
    input  logic [ADDR_WIDTH-1:0]   i_jump_address,
    output logic [$clog2(DEPTH):0]  o_empty_count
`ifdef CPU_FETCH_PERF_EN
    ,
    output logic [31:0]             o_fetch_count,
    output logic [31:0]             o_flush_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                  state_r;
    logic                    request_r;
    logic [ADDR_WIDTH-1:0]   address_r;
    logic [ADDR_WIDTH-1:0]   fetch_pc_r;
    logic                    stale_r;

    logic [DATA_WIDTH-1:0]   data_mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0]   pc_mem_r   [DEPTH];
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [CNT_W-1:0]        count_r;

    logic                    push_s;
    logic                    pop_s;
    logic [ADDR_WIDTH-1:0]   jump_target_s;
    logic                    jump_lsb_unused_s;

    // A redirect overrides both the response push and the decode pop.
    assign push_s = (state_r == ST_WAIT) && i_ready && !stale_r && !i_jump;
    assign pop_s  = (count_r != '0) && i_accept && !i_jump;

    assign jump_target_s     = {i_jump_address[ADDR_WIDTH-1:2], 2'b00};
    assign jump_lsb_unused_s = ^i_jump_address[1:0];

    assign o_rw          = 1'b0;
    assign o_request     = request_r;
    assign o_address     = address_r;
    assign o_valid       = (count_r != '0);
    assign o_instruction = data_mem_r[rd_ptr_r];
    assign o_pc          = pc_mem_r[rd_ptr_r];
    assign o_empty_count = DEPTH_C - count_r;

    // Bus request sequencer, fetch PC and stale-response tracking.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r    <= ST_IDLE;
            request_r  <= 1'b0;
            address_r  <= '0;
            fetch_pc_r <= RESET_VECTOR;
            stale_r    <= 1'b0;
        end else if (i_jump) begin
            fetch_pc_r <= jump_target_s;
            if (state_r == ST_WAIT) begin
                if (i_ready) begin
                    request_r <= 1'b0;
                    state_r   <= ST_IDLE;
                    stale_r   <= 1'b0;
                end else begin
                    stale_r   <= 1'b1;
                end
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // The slot is effectively reserved at issue: only one request is ever outstanding.
                    if (count_r < DEPTH_C) begin
                        address_r <= fetch_pc_r;
                        request_r <= 1'b1;
                        state_r   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_ready) begin
                        request_r <= 1'b0;
                        state_r   <= ST_IDLE;
                        if (stale_r) begin
                            stale_r <= 1'b0;
                        end else begin
                            fetch_pc_r <= fetch_pc_r + PC_STEP;
                        end
                    end
                end
                default: begin
                    request_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO storage, pointers and occupancy; a redirect empties it in one cycle.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_r[i] <= '0;
                pc_mem_r[i]   <= '0;
            end
        end else if (i_jump) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                data_mem_r[wr_ptr_r] <= i_data;
                pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef CPU_FETCH_PERF_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] flush_cnt_r;

    assign o_fetch_count = fetch_cnt_r;
    assign o_flush_count = flush_cnt_r;

    // Free-running event counters for fetched words and redirect cycles.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            fetch_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (push_s) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end
            if (i_jump) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Directed self-checking bench for cpu_fetch_queue with a small request/ready memory model.
module tb_cpu_fetch_queue;

    logic        i_clock;
    logic        i_reset;
    logic        o_rw;
    logic        o_request;
    logic        i_ready;
    logic [31:0] o_address;
    logic [31:0] i_data;
    logic        o_valid;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;
    logic        i_accept;
    logic        i_jump;
    logic [31:0] i_jump_address;
    logic [2:0]  o_empty_count;
`ifdef CPU_FETCH_PERF_EN
    logic [31:0] o_fetch_count;
    logic [31:0] o_flush_count;
`endif

    cpu_fetch_queue dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .o_rw           (o_rw),
        .o_request      (o_request),
        .i_ready        (i_ready),
        .o_address      (o_address),
        .i_data         (i_data),
        .o_valid        (o_valid),
        .o_instruction  (o_instruction),
        .o_pc           (o_pc),
        .i_accept       (i_accept),
        .i_jump         (i_jump),
        .i_jump_address (i_jump_address),
        .o_empty_count  (o_empty_count)
`ifdef CPU_FETCH_PERF_EN
        ,
        .o_fetch_count  (o_fetch_count),
        .o_flush_count  (o_flush_count)
`endif
    );

    localparam logic [31:0] BEEF = 32'hDEAD_BEEF;
    localparam logic [31:0] BAD0 = 32'hBAD0_BAD0;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          mem_lat = 1;
    bit          mem_en = 1'b1;
    bit          beef_mode = 1'b0;
    int          wait_cnt = 0;
    bit          prev_req = 1'b0;
    logic [31:0] held_addr = 32'h0;
    int          stable_err = 0;
    int          bad_seen = 0;
    logic [31:0] req_q [$];

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    function automatic logic [31:0] resp(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] first_req();
        return (req_q.size() > 0) ? req_q[0] : 32'hFFFF_FFFF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: answers a request after mem_lat extra cycles, logs each new request address.
    initial begin
        i_ready = 1'b0;
        i_data  = 32'h0;
        forever begin
            @(posedge i_clock);
            #1;
            if (o_request && prev_req && o_address != held_addr) stable_err++;
            if (o_request && !prev_req) begin
                req_q.push_back(o_address);
                held_addr = o_address;
            end
            prev_req = o_request;
            if (i_ready) begin
                i_ready  = 1'b0;
                wait_cnt = 0;
            end else if (mem_en && o_request) begin
                if (wait_cnt >= mem_lat) begin
                    i_ready   = 1'b1;
                    i_data    = beef_mode ? BEEF : resp(o_address);
                    beef_mode = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Watch for discarded data ever reaching the head.
    always @(negedge i_clock) begin
        if (o_valid && (o_instruction == BEEF || o_instruction == BAD0)) bad_seen++;
    end

    initial begin
        logic [31:0] exp_pc;
        int pops;
        int hits;

        i_reset = 1'b0;
        i_accept = 1'b0;
        i_jump = 1'b0;
        i_jump_address = 32'h0;
        repeat (2) @(negedge i_clock);

        // Reset state
        check("rst_request", o_request, 1'b0);
        check("rst_rw", o_rw, 1'b0);
        check("rst_address", o_address, 32'h0);
        check("rst_valid", o_valid, 1'b0);
        check("rst_empty", o_empty_count, 3'd4);

        // Fill from reset vector with no decode pops
        req_q.delete();
        i_reset = 1'b1;
        for (int k = 0; k < 100 && o_empty_count != 3'd0; k++) @(negedge i_clock);
        check("fill_timeout", o_empty_count, 3'd0);
        repeat (6) @(negedge i_clock);
        check("fill_request_idle", o_request, 1'b0);
        check("fill_empty", o_empty_count, 3'd0);
        check("fill_head_pc", o_pc, 32'h200);
        check("fill_head_instr", o_instruction, resp(32'h200));
        check("fill_req_count", req_q.size(), 4);
        for (int i = 0; i < 4 && i < req_q.size(); i++)
            check("fill_req_addr", req_q[i], 32'h200 + 32'(4 * i));

        // Streaming pops with single-cycle ready, past the pointer wrap
        mem_lat = 0;
        i_accept = 1'b1;
        exp_pc = 32'h200;
        pops = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_valid) begin
                check("stream_pc", o_pc, exp_pc);
                check("stream_instr", o_instruction, resp(exp_pc));
                exp_pc += 32'd4;
                pops++;
            end
            @(negedge i_clock);
        end
        i_accept = 1'b0;
        check("stream_wrap_reached", pops >= 8, 1'b1);

        // Jump with 3 entries held and no request pending
        mem_lat = 1;
        for (int k = 0; k < 100 && o_empty_count != 3'd0; k++) @(negedge i_clock);
        check("j1_full_timeout", o_empty_count, 3'd0);
        i_accept = 1'b1;
        @(negedge i_clock);
        i_accept = 1'b0;
        check("j1_pre_empty", o_empty_count, 3'd1);
        check("j1_pre_request", o_request, 1'b0);
        req_q.delete();
        i_jump = 1'b1;
        i_jump_address = 32'h1003;
        @(negedge i_clock);
        i_jump = 1'b0;
        check("j1_valid_cleared", o_valid, 1'b0);
        check("j1_empty", o_empty_count, 3'd4);
        for (int k = 0; k < 50 && !o_valid; k++) @(negedge i_clock);
        check("j1_req_addr", first_req(), 32'h1000);
        check("j1_head_pc", o_pc, 32'h1000);
        check("j1_head_instr", o_instruction, resp(32'h1000));

        // Jump while a request is waiting; stale response arrives later
        mem_en = 1'b0;
        i_accept = 1'b1;
        for (int k = 0; k < 50 && !(o_request && !o_valid); k++) @(negedge i_clock);
        i_accept = 1'b0;
        check("j2_pending", o_request, 1'b1);
        req_q.delete();
        bad_seen = 0;
        stable_err = 0;
        i_jump = 1'b1;
        i_jump_address = 32'h3000;
        @(negedge i_clock);
        i_jump = 1'b0;
        check("j2_request_held", o_request, 1'b1);
        mem_lat = 3;
        beef_mode = 1'b1;
        mem_en = 1'b1;
        for (int k = 0; k < 50 && !o_valid; k++) @(negedge i_clock);
        check("j2_head_pc", o_pc, 32'h3000);
        check("j2_head_instr", o_instruction, resp(32'h3000));
        check("j2_req_addr", first_req(), 32'h3000);
        mem_lat = 1;
        repeat (10) @(negedge i_clock);
        check("j2_addr_stable", stable_err, 0);
        check("j2_stale_hidden", bad_seen, 0);

        // Jump together with ready and accept in the same cycle
        for (int k = 0; k < 100 && o_empty_count != 3'd0; k++) @(negedge i_clock);
        mem_en = 1'b0;
        i_accept = 1'b1;
        @(negedge i_clock);
        i_accept = 1'b0;
        for (int k = 0; k < 20 && !o_request; k++) @(negedge i_clock);
        check("j3_pending", o_request, 1'b1);
        check("j3_pre_valid", o_valid, 1'b1);
        req_q.delete();
        i_jump = 1'b1;
        i_jump_address = 32'h4000;
        i_ready = 1'b1;
        i_data = BAD0;
        i_accept = 1'b1;
        @(negedge i_clock);
        i_jump = 1'b0;
        i_ready = 1'b0;
        i_accept = 1'b0;
        check("j3_valid_cleared", o_valid, 1'b0);
        check("j3_empty", o_empty_count, 3'd4);
        check("j3_request_dropped", o_request, 1'b0);
        mem_en = 1'b1;
        for (int k = 0; k < 100 && o_empty_count != 3'd0; k++) @(negedge i_clock);
        check("j3_head_pc", o_pc, 32'h4000);
        check("j3_head_instr", o_instruction, resp(32'h4000));
        check("j3_req_count", req_q.size(), 4);
        hits = 0;
        foreach (req_q[i]) if (req_q[i] == 32'h4000) hits++;
        check("j3_single_target_req", hits, 1);
        check("j3_dropped_hidden", bad_seen, 0);

        // Asynchronous reset while waiting on the bus
        mem_en = 1'b0;
        i_accept = 1'b1;
        @(negedge i_clock);
        i_accept = 1'b0;
        for (int k = 0; k < 20 && !o_request; k++) @(negedge i_clock);
        check("r_pending", o_request, 1'b1);
        #2;
        i_reset = 1'b0;
        #1;
        check("r_request_async", o_request, 1'b0);
        check("r_valid_async", o_valid, 1'b0);
        check("r_empty_async", o_empty_count, 3'd4);
`ifdef CPU_FETCH_PERF_EN
        check("r_fetch_count", o_fetch_count, 32'd0);
        check("r_flush_count", o_flush_count, 32'd0);
`endif
        @(negedge i_clock);
        req_q.delete();
        mem_en = 1'b1;
        i_reset = 1'b1;
        for (int k = 0; k < 50 && !o_valid; k++) @(negedge i_clock);
        check("r_req_addr", first_req(), 32'h200);
        check("r_head_pc", o_pc, 32'h200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
